// File: rtl/cpu_pkg.sv
// Shared definitions for the LEGv8 fetch path.
// Fetch FSM encoding, instruction width and memory-size defaults.
package cpu_pkg;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED,
    FAULT
  } fetch_state_t;

  localparam int INSTR_W = 32;
  localparam int PC_INC = 4;
  localparam int IMEM_BYTES_DEF = 4096;
  localparam logic [10:0] HALT_OPCODE_DEF = 11'h7FF;

endpackage

// File: rtl/fetch_sequencer_ifid_reg.sv
// IF/ID pipeline register with hold and clear controls.
// Clear drops only the valid bit; the stale word and PC are kept.
module ifid_reg
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hold,
  input  logic               clear,
  input  logic [INSTR_W-1:0] instr_d,
  input  logic [ADDR_W-1:0]  pc_d,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (!hold) begin
      valid <= 1'b1;
      instr <= instr_d;
      pc    <= pc_d;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// PC register, fetch FSM and IF/ID register for the LEGv8 core.
// FETCH_PERF_CNT_EN enables the saturating performance counters.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int          ADDR_W       = 64,
  parameter int          IMEM_BYTES   = IMEM_BYTES_DEF,
  parameter int          DRAIN_CYCLES = 4,
  parameter logic [10:0] HALT_OPCODE  = HALT_OPCODE_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               pc_src,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_rd,
  input  logic [INSTR_W-1:0] instr_in,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc,
  output logic               flush,
  output logic               halted,
  output logic               fault,
  output logic [31:0]        perf_fetch,
  output logic [31:0]        perf_stall,
  output logic [31:0]        perf_flush
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES) + 1;
  localparam logic [ADDR_W-1:0] LAST_PC =
    ADDR_W'(IMEM_BYTES - PC_INC);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DRAIN_CYCLES - 1);

  fetch_state_t      state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              flush_n;
  logic              hold, clear;
  logic              bad_target, is_halt, seq_end;

  assign bad_target = (branch_target[1:0] != 2'b00) ||
                      (branch_target > LAST_PC);
  assign is_halt = (instr_in[31:21] == HALT_OPCODE);
  // pc+4 past the last word, written overflow-free
  assign seq_end = (pc >= LAST_PC);

  assign imem_addr = pc;
  assign imem_rd   = (state == RUN) && !reset;
  assign halted    = (state == HALTED);
  assign fault     = (state == FAULT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      pc    <= '0;
      cnt   <= '0;
      flush <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      cnt   <= cnt_n;
      flush <= flush_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    cnt_n   = cnt;
    flush_n = 1'b0;
    hold    = 1'b1;
    clear   = 1'b0;
    unique case (state)
      RUN, DRAIN: begin
        if (pc_src) begin
          clear = 1'b1;
          if (bad_target) begin
            state_n = FAULT;
          end else begin
            state_n = RUN;
            pc_n    = branch_target;
            flush_n = 1'b1;
          end
        end else if (stall) begin
          hold = 1'b1;
        end else if (state == RUN) begin
          hold = 1'b0;
          if (is_halt) begin
            state_n = DRAIN;
            cnt_n   = '0;
          end else if (seq_end) begin
            state_n = FAULT;
            clear   = 1'b1;
          end else begin
            pc_n = pc + ADDR_W'(PC_INC);
          end
        end else begin
          clear = 1'b1;
          cnt_n = cnt + 1'b1;
          if (cnt == CNT_LAST) state_n = HALTED;
        end
      end
      HALTED, FAULT: begin
        hold = 1'b1;
      end
    endcase
  end

  ifid_reg #(
    .ADDR_W(ADDR_W)
  ) u_ifid (
    .clk    (clk),
    .reset  (reset),
    .hold   (hold),
    .clear  (clear),
    .instr_d(instr_in),
    .pc_d   (pc),
    .valid  (ifid_valid),
    .instr  (ifid_instr),
    .pc     (ifid_pc)
  );

`ifdef FETCH_PERF_CNT_EN
  logic        live, ev_fetch, ev_stall;
  logic [31:0] cnt_fetch, cnt_stall, cnt_flush;

  assign live     = (state == RUN) || (state == DRAIN);
  assign ev_fetch = !hold && !clear ||
                    (state == RUN && !pc_src && !stall);
  assign ev_stall = live && stall && !pc_src;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_fetch <= '0;
      cnt_stall <= '0;
      cnt_flush <= '0;
    end else begin
      if (ev_fetch && cnt_fetch != '1) cnt_fetch <= cnt_fetch + 1'b1;
      if (ev_stall && cnt_stall != '1) cnt_stall <= cnt_stall + 1'b1;
      if (flush_n && cnt_flush != '1) cnt_flush <= cnt_flush + 1'b1;
    end
  end

  assign perf_fetch = cnt_fetch;
  assign perf_stall = cnt_stall;
  assign perf_flush = cnt_flush;
`else
  assign perf_fetch = '0;
  assign perf_stall = '0;
  assign perf_flush = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer.
// Perf expectations follow FETCH_PERF_CNT_EN (zero when undefined).
module tb_fetch_sequencer;

  localparam int PERF =
`ifdef FETCH_PERF_CNT_EN
    1;
`else
    0;
`endif

  localparam logic [31:0] HALT_W = 32'hFFE00000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        pc_src = 1'b0;
  logic [63:0] branch_target = '0;
  logic [63:0] imem_addr;
  logic        imem_rd;
  logic [31:0] instr_in;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [63:0] ifid_pc;
  logic        flush, halted, fault;
  logic [31:0] perf_fetch, perf_stall, perf_flush;

  logic [31:0] mem [1024];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always_comb instr_in = mem[imem_addr[11:2]];

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .pc_src(pc_src),
    .branch_target(branch_target), .imem_addr(imem_addr),
    .imem_rd(imem_rd), .instr_in(instr_in),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr),
    .ifid_pc(ifid_pc), .flush(flush), .halted(halted),
    .fault(fault), .perf_fetch(perf_fetch),
    .perf_stall(perf_stall), .perf_flush(perf_flush)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 1024; i++) mem[i] = 32'h8B000000 | i;
    stall = 0; pc_src = 0; branch_target = '0;
    reset = 1;
    tick();
    reset = 0;
    #1;
  endtask

  task automatic test_reset();
    stall = 1; pc_src = 1; branch_target = 64'h40; reset = 1;
    tick();
    checks++; if (imem_addr !== 64'h0) begin failures++;
      $display("FAIL rst_addr got=%0h exp=0", imem_addr); end
    checks++; if (imem_rd !== 1'b0) begin failures++;
      $display("FAIL rst_rd got=%b exp=0", imem_rd); end
    checks++; if ({ifid_valid, flush, halted, fault} !== 4'b0) begin
      failures++; $display("FAIL rst_flags got=%b exp=0000",
        {ifid_valid, flush, halted, fault}); end
    checks++; if ({ifid_instr, ifid_pc} !== 96'h0) begin failures++;
      $display("FAIL rst_ifid got=%0h/%0h exp=0", ifid_instr, ifid_pc); end
    checks++; if ({perf_fetch, perf_stall, perf_flush} !== 96'h0) begin
      failures++; $display("FAIL rst_perf got=%0h exp=0",
        {perf_fetch, perf_stall, perf_flush}); end
    do_reset();
    checks++; if (imem_rd !== 1'b1) begin failures++;
      $display("FAIL rst_rd_release got=%b exp=1", imem_rd); end
  endtask

  task automatic test_sequential();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (ifid_pc !== 64'(i * 4) || ifid_valid !== 1'b1 ||
                    ifid_instr !== (32'h8B000000 | i)) begin failures++;
        $display("FAIL seq_%0d got=%0h/%b/%0h exp=%0h/1/%0h", i, ifid_pc,
          ifid_valid, ifid_instr, i * 4, 32'h8B000000 | i); end
    end
    checks++; if (perf_fetch !== 32'(PERF * 4)) begin failures++;
      $display("FAIL seq_perf got=%0d exp=%0d", perf_fetch, PERF * 4); end
  endtask

  task automatic test_stall();
    do_reset();
    tick(); tick();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (imem_addr !== 64'h8 || ifid_pc !== 64'h4 ||
                    ifid_valid !== 1'b1 || flush !== 1'b0) begin
        failures++; $display("FAIL stall_%0d got=%0h/%0h/%b exp=8/4/1",
          i, imem_addr, ifid_pc, ifid_valid); end
    end
    stall = 0;
    checks++; if (perf_stall !== 32'(PERF * 3)) begin failures++;
      $display("FAIL stall_perf got=%0d exp=%0d", perf_stall, PERF * 3); end
    tick();
    checks++; if (ifid_pc !== 64'h8 || imem_addr !== 64'hC) begin
      failures++; $display("FAIL stall_resume got=%0h/%0h exp=8/c",
        ifid_pc, imem_addr); end
  endtask

  task automatic test_branch(input logic with_stall);
    do_reset();
    repeat (4) tick();
    pc_src = 1; branch_target = 64'h40; stall = with_stall;
    tick();
    checks++; if (flush !== 1'b1 || ifid_valid !== 1'b0 ||
                  imem_addr !== 64'h40) begin failures++;
      $display("FAIL br_redirect_s%0b got=%b/%b/%0h exp=1/0/40",
        with_stall, flush, ifid_valid, imem_addr); end
    pc_src = 0; stall = 0;
    tick();
    checks++; if (flush !== 1'b0 || ifid_pc !== 64'h40 ||
                  ifid_valid !== 1'b1) begin failures++;
      $display("FAIL br_next_s%0b got=%b/%0h/%b exp=0/40/1",
        with_stall, flush, ifid_pc, ifid_valid); end
    checks++; if (perf_flush !== 32'(PERF) || perf_stall !== 32'h0) begin
      failures++; $display("FAIL br_perf_s%0b got=%0d/%0d exp=%0d/0",
        with_stall, perf_flush, perf_stall, PERF); end
  endtask

  task automatic test_halt();
    do_reset();
    mem[3] = HALT_W;
    repeat (4) tick();
    checks++; if (ifid_instr !== HALT_W || ifid_valid !== 1'b1 ||
                  imem_rd !== 1'b0 || imem_addr !== 64'hC) begin
      failures++; $display("FAIL halt_cap got=%0h/%b/%b/%0h exp=ffe00000/1/0/c",
        ifid_instr, ifid_valid, imem_rd, imem_addr); end
    stall = 1;
    tick();
    stall = 0;
    checks++; if (ifid_valid !== 1'b1 || halted !== 1'b0) begin
      failures++; $display("FAIL halt_stall got=%b/%b exp=1/0",
        ifid_valid, halted); end
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++; if (ifid_valid !== 1'b0 || halted !== (k == 4)) begin
        failures++; $display("FAIL halt_drain_%0d got=%b/%b exp=0/%b",
          k, ifid_valid, halted, k == 4); end
    end
    pc_src = 1; branch_target = 64'h40;
    tick(); tick();
    pc_src = 0;
    checks++; if (halted !== 1'b1 || imem_addr !== 64'hC ||
                  flush !== 1'b0 || imem_rd !== 1'b0) begin failures++;
      $display("FAIL halt_sticky got=%b/%0h/%b exp=1/c/0",
        halted, imem_addr, flush); end
  endtask

  task automatic test_wrong_path();
    do_reset();
    mem[3] = HALT_W;
    repeat (5) tick();
    pc_src = 1; branch_target = 64'h20;
    tick();
    pc_src = 0;
    checks++; if (flush !== 1'b1 || imem_addr !== 64'h20 ||
                  imem_rd !== 1'b1 || halted !== 1'b0) begin failures++;
      $display("FAIL wp_redirect got=%b/%0h/%b/%b exp=1/20/1/0",
        flush, imem_addr, imem_rd, halted); end
    tick();
    checks++; if (ifid_pc !== 64'h20 || ifid_valid !== 1'b1 ||
                  ifid_instr !== 32'h8B000008) begin failures++;
      $display("FAIL wp_resume got=%0h/%b/%0h exp=20/1/8b000008",
        ifid_pc, ifid_valid, ifid_instr); end
    repeat (5) tick();
    checks++; if (halted !== 1'b0 || imem_addr !== 64'h38) begin
      failures++; $display("FAIL wp_nohalt got=%b/%0h exp=0/38",
        halted, imem_addr); end
  endtask

  task automatic test_fault();
    do_reset();
    tick();
    pc_src = 1; branch_target = 64'h22;
    tick();
    pc_src = 0;
    checks++; if (fault !== 1'b1 || imem_rd !== 1'b0 ||
                  imem_addr !== 64'h4 || ifid_valid !== 1'b0) begin
      failures++; $display("FAIL flt_misalign got=%b/%b/%0h/%b exp=1/0/4/0",
        fault, imem_rd, imem_addr, ifid_valid); end
    tick();
    checks++; if (fault !== 1'b1 || flush !== 1'b0) begin failures++;
      $display("FAIL flt_sticky got=%b/%b exp=1/0", fault, flush); end
    do_reset();
    pc_src = 1; branch_target = 64'd4096;
    tick();
    pc_src = 0;
    checks++; if (fault !== 1'b1 || imem_addr !== 64'h0) begin failures++;
      $display("FAIL flt_range got=%b/%0h exp=1/0", fault, imem_addr); end
    do_reset();
    pc_src = 1; branch_target = 64'd4092;
    tick();
    pc_src = 0;
    checks++; if (fault !== 1'b0 || imem_addr !== 64'd4092 ||
                  flush !== 1'b1) begin failures++;
      $display("FAIL flt_lastok got=%b/%0d exp=0/4092", fault, imem_addr); end
    tick();
    checks++; if (fault !== 1'b1) begin failures++;
      $display("FAIL flt_seqend got=%b exp=1", fault); end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    mem[3] = HALT_W;
    repeat (5) tick();
    reset = 1;
    tick();
    checks++; if (imem_addr !== 64'h0 || halted !== 1'b0 ||
                  fault !== 1'b0 || ifid_valid !== 1'b0) begin failures++;
      $display("FAIL rst_drain got=%0h/%b/%b/%b exp=0/0/0/0",
        imem_addr, halted, fault, ifid_valid); end
    reset = 0;
    #1;
    checks++; if (imem_rd !== 1'b1) begin failures++;
      $display("FAIL rst_drain_rd got=%b exp=1", imem_rd); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h8B000000 | i;
    test_reset();
    test_sequential();
    test_stall();
    test_branch(1'b0);
    test_branch(1'b1);
    test_halt();
    test_wrong_path();
    test_fault();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Owns the program counter and the IF/ID pipeline register for the LEGv8 5-stage core.
- Each cycle it issues a byte address to the instruction memory and captures the returned word together with its PC into IF/ID.
- Applies stalls from the hazard unit and redirects from the branch unit.
- On the all-ones HALT opcode it stops fetching, drains the pipeline for a fixed number of cycles, then asserts halted.

Parameters:
ADDR_W, 64, PC / address width in bits
IMEM_BYTES, 4096, instruction memory size in bytes; valid PCs are 0..IMEM_BYTES-4
DRAIN_CYCLES, 4, cycles after HALT enters IF/ID before halted asserts (pipeline depth minus 1)
HALT_OPCODE, 11'h7FF, value of instr[31:21] that marks HALT

Ports:
clk  in  1  system clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
stall  in  1  hazard-unit stall: hold PC and IF/ID
pc_src  in  1  branch taken, from the branch unit
branch_target  in  ADDR_W  redirect byte address, valid when pc_src=1
imem_addr  out  ADDR_W  fetch byte address (equals current PC)
imem_rd  out  1  fetch enable
instr_in  in  32  little-endian assembled word at imem_addr; combinational, same cycle
ifid_valid  out  1  IF/ID holds a real instruction
ifid_instr  out  32  IF/ID instruction
ifid_pc  out  ADDR_W  PC of ifid_instr
flush  out  1  one-cycle pulse when a redirect squashes IF/ID
halted  out  1  sticky; HALT fully drained
fault  out  1  sticky; redirect to a misaligned or out-of-range address
perf_fetch, perf_stall, perf_flush  out  32 each  performance counters (see Optional Feature)

Behaviour:
- Reset values (synchronous, dominates all other inputs): PC=0, state=RUN, imem_rd=0, ifid_valid=0, ifid_instr=0, ifid_pc=0, flush=0, halted=0, fault=0, drain count=0, perf counters=0.
- imem_rd is combinational: 1 iff state==RUN and reset==0.
- States: RUN, DRAIN, HALTED, FAULT.
- Per-cycle priority in RUN and DRAIN: pc_src > stall > normal advance.
- RUN, redirect:
  - If branch_target[1:0]!=0 or branch_target>IMEM_BYTES-4: go to FAULT; PC unchanged; ifid_valid<=0.
  - Otherwise: PC<=branch_target, ifid_valid<=0 (bubble), flush<=1 for exactly one cycle.
- RUN, stall (no redirect): PC, ifid_* and flush=0 held.
- RUN, normal: ifid_instr<=instr_in, ifid_pc<=PC, ifid_valid<=1, PC<=PC+4 (mod 2^ADDR_W).
  - If instr_in[31:21]==HALT_OPCODE: also go to DRAIN with count<=0; PC is not incremented.
- RUN, sequential end of memory: if PC+4 would exceed IMEM_BYTES-4 on a non-HALT word, go to FAULT.
- DRAIN:
  - No fetch. On the first non-stalled cycle, ifid_valid<=0.
  - Count increments only on non-stalled cycles; count==DRAIN_CYCLES-1 -> HALTED.
- DRAIN, redirect: the HALT was wrong-path. Cancel the drain, go to RUN, and apply the redirect rules (flush=1, PC<=target).
- HALTED: halted=1, ifid_valid=0; all inputs ignored until reset.
- FAULT: fault=1, ifid_valid=0; all inputs ignored until reset.
- Reset mid-DRAIN, mid-stall or mid-FAULT returns to the reset values on the next edge.
- pc_src and stall asserted together: the redirect wins and the stall is ignored for that cycle.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: three 32-bit saturating counters, all cleared on reset.
  - perf_fetch: increments on each IF/ID capture.
  - perf_stall: increments on each stalled cycle in RUN or DRAIN.
  - perf_flush: increments on each flush pulse.
- Undefined: the ports remain and are tied to 0; no counter registers are synthesised.

Decomposition:
- Shared package (cpu_pkg): fetch state encoding (RUN/DRAIN/HALTED/FAULT), HALT_OPCODE, INSTR_W=32, the PC increment constant 4, and the IMEM_BYTES default.
- One sub-module: ifid_reg, the IF/ID pipeline register with hold and clear controls.
- The PC register and FSM stay in fetch_sequencer.

Test Plan:
- Sequential run: IMEM holds ADD words at 0..12, no stall. ifid_pc reads 0,4,8,12 on consecutive cycles, ifid_valid=1, perf_fetch=4.
- Stall: stall=1 for 3 cycles at PC=8. imem_addr stays 8, ifid_* unchanged, perf_stall=3, then the sequence resumes at 8.
- Branch: pc_src=1 with target=0x40 while PC=0x10. flush pulses 1 cycle, ifid_valid=0 that cycle, next ifid_pc=0x40. Repeat with stall=1 in the same cycle: identical result.
- HALT: HALT word (0xFFE00000) at 0x0C. imem_rd=0 after capture, ifid_valid falls the next cycle, halted=1 exactly 4 non-stalled cycles later, and remains 1.
- Wrong-path HALT: pc_src=1 with target=0x20 one cycle into DRAIN. Returns to RUN, flush=1, fetch resumes at 0x20, halted stays 0.
- Fault and reset: target=0x22 gives fault=1, imem_rd=0. Then target=IMEM_BYTES gives fault. Asserting reset mid-DRAIN gives PC=0, halted=0, fault=0 on the next edge.
